// File: rtl/atm_keypad_entry.sv
// Two-digit keypad entry controller for a room access panel: captures digits, presents the code
// to the room controller, counts consecutive denials and locks the keypad out after too many.
module atm_keypad_entry #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned LOCKOUT_CYCLES = 64,
   parameter int unsigned MAX_FAILS      = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       key_press_i,
   input  logic [1:0] key_code_i,
   input  logic       key_clear_i,
   input  logic       key_enter_i,
   input  logic       grant_i,
   input  logic       deny_i,
   output logic [1:0] passcode_digit_1_o,
   output logic [1:0] passcode_digit_2_o,
   output logic       code_valid_o,
   output logic [1:0] digit_count_o,
   output logic [1:0] fail_count_o,
   output logic       lockout_o
);

   localparam int unsigned CntMax = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : LOCKOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] LockLast    = CntW'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]      MaxFails    = 2'(MAX_FAILS);

   typedef enum logic [2:0] {StEmpty, StOneDigit, StTwoDigits, StPresent, StLocked} state_e;

   state_e            state_q, state_d;
   logic [1:0]        dig1_q, dig1_d, dig2_q, dig2_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        fail_q, fail_d;
   logic [1:0]        pd1_q, pd1_d, pd2_q, pd2_d;
   logic              valid_q, valid_d;
   logic [1:0]        dcount_q, dcount_d;
   logic              lock_q, lock_d;
   logic [1:0]        fail_inc;

   always_comb begin
      state_d  = state_q;
      dig1_d   = dig1_q;
      dig2_d   = dig2_q;
      cnt_d    = cnt_q;
      fail_d   = fail_q;
      fail_inc = (fail_q >= MaxFails) ? MaxFails : fail_q + 2'd1;

      unique case (state_q)
         StEmpty: begin
            if (key_clear_i) begin
               dig1_d = 2'b00;
               dig2_d = 2'b00;
            end else if (key_press_i) begin
               dig1_d  = key_code_i;
               state_d = StOneDigit;
               cnt_d   = '0;
            end
         end
         StOneDigit: begin
            if (key_clear_i) begin
               state_d = StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
               cnt_d   = '0;
            end else if (key_press_i) begin
               dig2_d  = key_code_i;
               state_d = StTwoDigits;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StTwoDigits: begin
            // Extra key presses neither overwrite digits nor restart the inactivity timer.
            if (key_clear_i) begin
               state_d = StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
               cnt_d   = '0;
            end else if (key_enter_i) begin
               state_d = StPresent;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StPresent: begin
            if (deny_i) begin
               fail_d  = fail_inc;
               state_d = (fail_inc == MaxFails) ? StLocked : StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
               cnt_d   = '0;
            end else if (grant_i) begin
               fail_d  = 2'b00;
               state_d = StEmpty;
               dig1_d  = 2'b00;
               dig2_d  = 2'b00;
            end
         end
         StLocked: begin
            if (cnt_q == LockLast) begin
               state_d = StEmpty;
               fail_d  = 2'b00;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StEmpty;
            dig1_d  = 2'b00;
            dig2_d  = 2'b00;
            cnt_d   = '0;
            fail_d  = 2'b00;
         end
      endcase

      // Outputs are registered copies derived from the next state.
      pd1_d    = (state_d == StPresent) ? dig1_d : 2'b00;
      pd2_d    = (state_d == StPresent) ? dig2_d : 2'b00;
      valid_d  = (state_d == StPresent);
      lock_d   = (state_d == StLocked);
      dcount_d = 2'd0;
      if (state_d == StOneDigit) dcount_d = 2'd1;
      if (state_d == StTwoDigits || state_d == StPresent) dcount_d = 2'd2;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StEmpty;
         dig1_q   <= 2'b00;
         dig2_q   <= 2'b00;
         cnt_q    <= '0;
         fail_q   <= 2'b00;
         pd1_q    <= 2'b00;
         pd2_q    <= 2'b00;
         valid_q  <= 1'b0;
         dcount_q <= 2'd0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dig1_q   <= dig1_d;
         dig2_q   <= dig2_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         pd1_q    <= pd1_d;
         pd2_q    <= pd2_d;
         valid_q  <= valid_d;
         dcount_q <= dcount_d;
         lock_q   <= lock_d;
      end
   end

   assign passcode_digit_1_o = pd1_q;
   assign passcode_digit_2_o = pd2_q;
   assign code_valid_o       = valid_q;
   assign digit_count_o      = dcount_q;
   assign fail_count_o       = fail_q;
   assign lockout_o          = lock_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: entry, grant, denial lockout, timeout, priorities, reset.
module tb_atm_keypad_entry;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       key_press_i = 1'b0;
   logic [1:0] key_code_i = 2'b00;
   logic       key_clear_i = 1'b0;
   logic       key_enter_i = 1'b0;
   logic       grant_i = 1'b0;
   logic       deny_i = 1'b0;
   logic [1:0] passcode_digit_1_o;
   logic [1:0] passcode_digit_2_o;
   logic       code_valid_o;
   logic [1:0] digit_count_o;
   logic [1:0] fail_count_o;
   logic       lockout_o;

   int checks = 0;
   int errors = 0;

   atm_keypad_entry #(
      .TIMEOUT_CYCLES(16),
      .LOCKOUT_CYCLES(64),
      .MAX_FAILS     (3)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .key_press_i       (key_press_i),
      .key_code_i        (key_code_i),
      .key_clear_i       (key_clear_i),
      .key_enter_i       (key_enter_i),
      .grant_i           (grant_i),
      .deny_i            (deny_i),
      .passcode_digit_1_o(passcode_digit_1_o),
      .passcode_digit_2_o(passcode_digit_2_o),
      .code_valid_o      (code_valid_o),
      .digit_count_o     (digit_count_o),
      .fail_count_o      (fail_count_o),
      .lockout_o         (lockout_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance n rising edges and settle 1ns past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic press(input logic [1:0] code);
      key_press_i = 1'b1;
      key_code_i  = code;
      cyc(1);
      key_press_i = 1'b0;
      key_code_i  = 2'b00;
   endtask

   task automatic enter();
      key_enter_i = 1'b1;
      cyc(1);
      key_enter_i = 1'b0;
   endtask

   task automatic respond(input logic g, input logic d);
      grant_i = g;
      deny_i  = d;
      cyc(1);
      grant_i = 1'b0;
      deny_i  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({passcode_digit_1_o, passcode_digit_2_o, code_valid_o, digit_count_o, fail_count_o,
           lockout_o} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got d1=%b d2=%b cv=%b dc=%0d fc=%0d lo=%b want all zero",
                  passcode_digit_1_o, passcode_digit_2_o, code_valid_o, digit_count_o,
                  fail_count_o, lockout_o);
      end
      cyc(2);
      rst_ni = 1'b1;
      cyc(1);
   endtask

   task automatic test_grant();
      press(2'b01);
      checks++;
      if (digit_count_o !== 2'd1) begin
         errors++;
         $display("FAIL grant_dc1: got %0d want 1", digit_count_o);
      end
      press(2'b10);
      checks++;
      if (digit_count_o !== 2'd2 || passcode_digit_1_o !== 2'b00) begin
         errors++;
         $display("FAIL grant_dc2: got dc=%0d d1=%b want dc=2 d1=00", digit_count_o,
                  passcode_digit_1_o);
      end
      enter();
      checks++;
      if (code_valid_o !== 1'b1 || passcode_digit_1_o !== 2'b01 || passcode_digit_2_o !== 2'b10)
      begin
         errors++;
         $display("FAIL grant_present: got cv=%b d1=%b d2=%b want cv=1 d1=01 d2=10",
                  code_valid_o, passcode_digit_1_o, passcode_digit_2_o);
      end
      // Present must hold with no timeout and ignore keys.
      press(2'b11);
      cyc(20);
      checks++;
      if (code_valid_o !== 1'b1 || passcode_digit_2_o !== 2'b10) begin
         errors++;
         $display("FAIL present_hold: got cv=%b d2=%b want cv=1 d2=10", code_valid_o,
                  passcode_digit_2_o);
      end
      respond(1'b1, 1'b0);
      checks++;
      if (code_valid_o !== 1'b0 || fail_count_o !== 2'd0 || digit_count_o !== 2'd0 ||
          passcode_digit_1_o !== 2'b00) begin
         errors++;
         $display("FAIL grant_done: got cv=%b fc=%0d dc=%0d d1=%b want 0 0 0 00", code_valid_o,
                  fail_count_o, digit_count_o, passcode_digit_1_o);
      end
   endtask

   task automatic test_lockout();
      logic [1:0] exp_fc [3];
      exp_fc[0] = 2'd1;
      exp_fc[1] = 2'd2;
      exp_fc[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
         press(2'b11);
         press(2'b00);
         enter();
         respond(1'b0, 1'b1);
         checks++;
         if (fail_count_o !== exp_fc[i] || lockout_o !== (i == 2)) begin
            errors++;
            $display("FAIL deny_%0d: got fc=%0d lo=%b want fc=%0d lo=%b", i, fail_count_o,
                     lockout_o, exp_fc[i], (i == 2));
         end
      end
      press(2'b01);
      checks++;
      if (digit_count_o !== 2'd0 || lockout_o !== 1'b1) begin
         errors++;
         $display("FAIL lock_press: got dc=%0d lo=%b want dc=0 lo=1", digit_count_o, lockout_o);
      end
      cyc(62);
      checks++;
      if (lockout_o !== 1'b1) begin
         errors++;
         $display("FAIL lock_63: got lo=%b want 1", lockout_o);
      end
      cyc(1);
      checks++;
      if (lockout_o !== 1'b0 || fail_count_o !== 2'd0) begin
         errors++;
         $display("FAIL lock_end: got lo=%b fc=%0d want lo=0 fc=0", lockout_o, fail_count_o);
      end
   endtask

   task automatic test_timeout();
      press(2'b01);
      cyc(15);
      checks++;
      if (digit_count_o !== 2'd1) begin
         errors++;
         $display("FAIL timeout_15: got dc=%0d want 1", digit_count_o);
      end
      cyc(1);
      checks++;
      if (digit_count_o !== 2'd0) begin
         errors++;
         $display("FAIL timeout_16: got dc=%0d want 0", digit_count_o);
      end
      press(2'b01);
      cyc(15);
      press(2'b10);
      checks++;
      if (digit_count_o !== 2'd2) begin
         errors++;
         $display("FAIL timeout_rearm: got dc=%0d want 2", digit_count_o);
      end
      key_clear_i = 1'b1;
      cyc(1);
      key_clear_i = 1'b0;
      checks++;
      if (digit_count_o !== 2'd0) begin
         errors++;
         $display("FAIL clear: got dc=%0d want 0", digit_count_o);
      end
   endtask

   task automatic test_priority();
      press(2'b01);
      press(2'b10);
      press(2'b11);
      key_clear_i = 1'b1;
      key_enter_i = 1'b1;
      cyc(1);
      key_clear_i = 1'b0;
      key_enter_i = 1'b0;
      checks++;
      if (code_valid_o !== 1'b0 || digit_count_o !== 2'd0) begin
         errors++;
         $display("FAIL clear_enter: got cv=%b dc=%0d want cv=0 dc=0", code_valid_o,
                  digit_count_o);
      end
      press(2'b01);
      press(2'b10);
      press(2'b11);
      enter();
      checks++;
      if (passcode_digit_1_o !== 2'b01 || passcode_digit_2_o !== 2'b10) begin
         errors++;
         $display("FAIL no_overwrite: got d1=%b d2=%b want d1=01 d2=10", passcode_digit_1_o,
                  passcode_digit_2_o);
      end
      respond(1'b1, 1'b1);
      checks++;
      if (fail_count_o !== 2'd1 || code_valid_o !== 1'b0 || digit_count_o !== 2'd0) begin
         errors++;
         $display("FAIL grant_and_deny: got fc=%0d cv=%b dc=%0d want fc=1 cv=0 dc=0",
                  fail_count_o, code_valid_o, digit_count_o);
      end
      respond(1'b1, 1'b0);
      respond(1'b0, 1'b1);
      checks++;
      if (fail_count_o !== 2'd1 || code_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_resp: got fc=%0d cv=%b want fc=1 cv=0", fail_count_o, code_valid_o);
      end
   endtask

   task automatic test_async_reset();
      press(2'b11);
      press(2'b01);
      enter();
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (code_valid_o !== 1'b0 || passcode_digit_1_o !== 2'b00 || fail_count_o !== 2'd0) begin
         errors++;
         $display("FAIL rst_present: got cv=%b d1=%b fc=%0d want 0 00 0", code_valid_o,
                  passcode_digit_1_o, fail_count_o);
      end
      #1 rst_ni = 1'b1;
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         press(2'b11);
         press(2'b00);
         enter();
         respond(1'b0, 1'b1);
      end
      cyc(5);
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (lockout_o !== 1'b0 || fail_count_o !== 2'd0 || digit_count_o !== 2'd0) begin
         errors++;
         $display("FAIL rst_locked: got lo=%b fc=%0d dc=%0d want 0 0 0", lockout_o,
                  fail_count_o, digit_count_o);
      end
      #1 rst_ni = 1'b1;
      cyc(1);
      press(2'b10);
      checks++;
      if (digit_count_o !== 2'd1) begin
         errors++;
         $display("FAIL post_rst_press: got dc=%0d want 1", digit_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_grant();
      test_lockout();
      test_timeout();
      test_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, idle cycles allowed between key events before a partial entry is discarded.
REQ-002 The block SHALL have parameter LOCKOUT_CYCLES, default 64, duration of the lockout after too many failures.
REQ-003 The block SHALL have parameter MAX_FAILS, default 3, consecutive denials that trigger lockout.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 key_press  input  1  one-cycle strobe, digit key pressed.
REQ-007 key_code  input  2  digit value, sampled when key_press=1.
REQ-008 key_clear  input  1  one-cycle strobe, abandon current entry.
REQ-009 key_enter  input  1  one-cycle strobe, submit entry.
REQ-010 grant  input  1  one-cycle pulse from room controller, code accepted.
REQ-011 deny  input  1  one-cycle pulse from room controller, code rejected.
REQ-012 passcode_digit_1  output  2  first digit presented to room controller.
REQ-013 passcode_digit_2  output  2  second digit presented to room controller.
REQ-014 code_valid  output  1  high while a submitted code is presented.
REQ-015 digit_count  output  2  digits captured so far (0..2).
REQ-016 fail_count  output  2  consecutive denials since last grant or lockout.
REQ-017 lockout  output  1  high while keypad is locked out.

Function
REQ-018 The block SHALL implement a state machine with states EMPTY, ONE_DIGIT, TWO_DIGITS, PRESENT and LOCKED; all outputs registered.
REQ-019 EMPTY: key_press SHALL store key_code as digit 1 and go to ONE_DIGIT; digit_count=1 on the next cycle.
REQ-020 ONE_DIGIT: key_press SHALL store key_code as digit 2 and go to TWO_DIGITS; digit_count=2 on the next cycle.
REQ-021 TWO_DIGITS: key_press SHALL be ignored (no overwrite); key_enter SHALL go to PRESENT with code_valid=1 on the next cycle.
REQ-022 key_enter in EMPTY or ONE_DIGIT SHALL be ignored.
REQ-023 key_clear in EMPTY, ONE_DIGIT or TWO_DIGITS SHALL go to EMPTY and zero stored digits; same-cycle priority key_clear > key_enter > key_press.
REQ-024 An inactivity counter SHALL run in ONE_DIGIT and TWO_DIGITS, reset on every accepted key_press; after TIMEOUT_CYCLES consecutive cycles with no accepted key_press or key_enter, the state SHALL be EMPTY with digits zeroed.
REQ-025 passcode_digit_1/2 SHALL be 2'b00 in every state except PRESENT, where they carry the stored digits unchanged.
REQ-026 PRESENT: all key inputs SHALL be ignored; code_valid held high until grant or deny, with no timeout.
REQ-027 PRESENT + grant: go to EMPTY, fail_count=0, code_valid=0 on the next cycle.
REQ-028 PRESENT + deny: fail_count increments; if new value equals MAX_FAILS go to LOCKED, else EMPTY.
REQ-029 grant and deny in the same cycle SHALL be treated as deny.
REQ-030 grant/deny outside PRESENT SHALL be ignored.
REQ-031 LOCKED: lockout=1, all inputs ignored; after exactly LOCKOUT_CYCLES cycles in LOCKED go to EMPTY, fail_count=0, lockout=0.
REQ-032 fail_count SHALL saturate at MAX_FAILS and never wrap.

Reset
REQ-033 reset_n low SHALL immediately force EMPTY, digits 2'b00, code_valid=0, digit_count=0, fail_count=0, lockout=0, all counters 0, including mid-entry, mid-PRESENT and mid-LOCKED.
REQ-034 After reset_n deasserts, the first key_press SHALL be accepted as digit 1.

Verification
REQ-035 Press 01, press 10, enter -> code_valid=1, digit_1=01, digit_2=10; grant -> EMPTY, code_valid=0, fail_count=0.
REQ-036 Press 11, press 00, enter, deny, three times -> fail_count 1,2 then lockout=1; lockout clears after 64 cycles with fail_count=0; key_press during lockout leaves digit_count=0.
REQ-037 Press 01, idle 16 cycles -> digit_count=0; press 01, idle 15 cycles, press 10 -> digit_count=2.
REQ-038 Press 01, press 10, press 11 -> digits stay 01/10; key_clear+key_enter same cycle -> EMPTY, code_valid=0.
REQ-039 In PRESENT assert grant and deny together -> fail_count=1, EMPTY; grant pulse in EMPTY -> no change.
REQ-040 Assert reset_n low mid-PRESENT and mid-LOCKED -> all outputs at reset values immediately, before next clk edge.
